// File: rtl/boton_antirrebote_pkg.sv
// Shared definitions for the LED-game push-button front end.
// Holds the debouncer state encodings, the clock1k period and default parameters,
// plus a helper that checks the stability-counter width against the debounce length.
package boton_antirrebote_pkg;

  // Debouncer FSM encodings; all four 2-bit codes are used.
  typedef enum logic [1:0] {
    ESTABLE_0 = 2'd0,  // settled released
    VALIDA_1  = 2'd1,  // qualifying a press
    ESTABLE_1 = 2'd2,  // settled pressed
    VALIDA_0  = 2'd3   // qualifying a release
  } estado_t;

  // clock1k period: 1 ms, expressed in microseconds.
  localparam int CLOCK1K_PERIOD_US = 1000;

  // Default number of consecutive stable clock1k cycles needed to accept a level.
  localparam int DEBOUNCE_MS_DEFAULT = 20;

  // Default stability-counter width (holds 0..DEBOUNCE_MS_DEFAULT-1).
  localparam int CNT_W_DEFAULT = 5;

  // True when a CNT_W-bit counter can reach DEBOUNCE_MS-1 without wrapping.
  function automatic bit cnt_w_ok(input int debounce_ms, input int cnt_w);
    longint unsigned span;
    span = longint'(1) << cnt_w;
    return span > longint'(debounce_ms - 1);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for a single asynchronous input pin.
// Ports: clk (sampling clock), rst_n (async active-low, clears both flops),
//        d (asynchronous input), q (synchronised output, two clk edges behind d).
module sincronizador_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  // s1 may go metastable; s2 gives it a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/boton_antirrebote.sv
// Push-button debouncer feeding the pulse-to-impulse converter of the LED game.
// Ports: clock1k (1 kHz clock), reset_n (async active-low), botonRaw (raw bouncing pin),
//        botonLimpio (registered debounced level, 1 = pressed), subida/bajada (one-cycle edge strobes).
module boton_antirrebote
  import boton_antirrebote_pkg::*;
#(
  parameter int DEBOUNCE_MS      = DEBOUNCE_MS_DEFAULT,
  parameter int CNT_W            = CNT_W_DEFAULT,
  parameter bit POLARIDAD_ACTIVA = 1'b1
) (
  input  logic clock1k,
  input  logic reset_n,
  input  logic botonRaw,
  output logic botonLimpio,
  output logic subida,
  output logic bajada
);

  // Parameter sanity: a one-cycle window cannot filter anything, and the counter
  // must be able to hold DEBOUNCE_MS-1.
  if (DEBOUNCE_MS < 2) begin : g_chk_debounce
    $error("boton_antirrebote: DEBOUNCE_MS must be >= 2");
  end
  if (!cnt_w_ok(DEBOUNCE_MS, CNT_W)) begin : g_chk_cnt_w
    $error("boton_antirrebote: CNT_W too small for DEBOUNCE_MS");
  end

  // Terminal count: the cycle on which the counter reads this value with the
  // new level still present is the accepting cycle.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_MS - 1);

  // Normalise polarity so that b = 1 always means pressed.
  logic b;
  assign b = botonRaw ^ ~POLARIDAD_ACTIVA;

  logic s2;

  sincronizador_2ff u_sync_boton (
    .clk   (clock1k),
    .rst_n (reset_n),
    .d     (b),
    .q     (s2)
  );

  estado_t          state;
  estado_t          state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             limpio_next;
  logic             subida_next;
  logic             bajada_next;
  logic             cnt_done;

  assign cnt_done = (cnt == CNT_MAX);

  // State, counter and output registers.
  always_ff @(posedge clock1k or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ESTABLE_0;
      cnt         <= '0;
      botonLimpio <= 1'b0;
      subida      <= 1'b0;
      bajada      <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      botonLimpio <= limpio_next;
      subida      <= subida_next;
      bajada      <= bajada_next;
    end
  end

  // Next state and counter. The counter restarts on entry to a VALIDA state
  // and is left untouched (don't-care) while settled.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ESTABLE_0: begin
        if (s2) begin
          state_next = VALIDA_1;
          cnt_next   = '0;
        end
      end
      VALIDA_1: begin
        if (!s2) begin
          state_next = ESTABLE_0;        // bounce: drop the candidate press
        end else if (cnt_done) begin
          state_next = ESTABLE_1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ESTABLE_1: begin
        if (!s2) begin
          state_next = VALIDA_0;
          cnt_next   = '0;
        end
      end
      VALIDA_0: begin
        if (s2) begin
          state_next = ESTABLE_1;        // bounce: drop the candidate release
        end else if (cnt_done) begin
          state_next = ESTABLE_0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = ESTABLE_0;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs, computed one cycle ahead so they are registered alongside state.
  // The clean level follows the settled side of the FSM: pressed while in
  // ESTABLE_1 or still qualifying a release from it.
  always_comb begin
    limpio_next = (state_next == ESTABLE_1) || (state_next == VALIDA_0);
    subida_next = (state == VALIDA_1) && s2 && cnt_done;
    bajada_next = (state == VALIDA_0) && !s2 && cnt_done;
  end

endmodule

// File: tb/tb_boton_antirrebote.sv
// Directed bench for boton_antirrebote: reset, latency, bounce rejection,
// near-miss windows, reset mid-qualification and inverted input polarity.
module tb_boton_antirrebote;
  import boton_antirrebote_pkg::*;

  localparam int DEB = 20;

  logic clock1k = 1'b0;
  logic reset_n;
  logic raw;        // active-high instance
  logic raw2;       // active-low instance
  logic limpio, subida, bajada;
  logic limpio2, subida2, bajada2;

  int checks   = 0;
  int failures = 0;
  int sub_cnt[2];
  int baj_cnt[2];
  int both_cnt = 0;

  always #(CLOCK1K_PERIOD_US / 2) clock1k = ~clock1k;

  boton_antirrebote #(.DEBOUNCE_MS(DEB), .CNT_W(5), .POLARIDAD_ACTIVA(1'b1)) dut (
    .clock1k     (clock1k),
    .reset_n     (reset_n),
    .botonRaw    (raw),
    .botonLimpio (limpio),
    .subida      (subida),
    .bajada      (bajada)
  );

  boton_antirrebote #(.DEBOUNCE_MS(DEB), .CNT_W(5), .POLARIDAD_ACTIVA(1'b0)) dut_inv (
    .clock1k     (clock1k),
    .reset_n     (reset_n),
    .botonRaw    (raw2),
    .botonLimpio (limpio2),
    .subida      (subida2),
    .bajada      (bajada2)
  );

  typedef struct {
    logic raw;
    int   n;
    logic exp_limpio;
    int   exp_sub;
    int   exp_baj;
  } seg_t;

  seg_t segs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; tally strobes.
  task automatic step();
    @(posedge clock1k);
    #1;
    if (subida  === 1'b1) sub_cnt[0]++;
    if (bajada  === 1'b1) baj_cnt[0]++;
    if (subida2 === 1'b1) sub_cnt[1]++;
    if (bajada2 === 1'b1) baj_cnt[1]++;
    if (subida === 1'b1 && bajada === 1'b1) both_cnt++;
    if (subida2 === 1'b1 && bajada2 === 1'b1) both_cnt++;
  endtask

  task automatic clear_counts();
    sub_cnt[0] = 0; baj_cnt[0] = 0;
    sub_cnt[1] = 0; baj_cnt[1] = 0;
  endtask

  function automatic logic get_lim(input int sel);
    return (sel == 0) ? limpio : limpio2;
  endfunction

  function automatic logic get_strobe(input int sel, input logic rise);
    if (sel == 0) return rise ? subida : bajada;
    return rise ? subida2 : bajada2;
  endfunction

  // Caller has just changed the input right after an edge; the next edge is
  // edge 1. The clean level must hold through edge DEB+2 and flip on DEB+3,
  // with exactly one strobe of the matching kind.
  task automatic latency_check(input string name, input int sel, input logic rise);
    int early;
    int same_cnt;
    int other_cnt;
    early = 0;
    clear_counts();
    for (int e = 1; e <= DEB + 3; e++) begin
      step();
      if (e < DEB + 3 && get_lim(sel) !== ~rise) early++;
    end
    check({name, "_early_change"}, early, 0);
    check({name, "_level_edge23"}, get_lim(sel), rise);
    check({name, "_strobe_edge23"}, get_strobe(sel, rise), 1'b1);
    step();
    check({name, "_strobe_one_cycle"}, get_strobe(sel, rise), 1'b0);
    same_cnt  = rise ? sub_cnt[sel] : baj_cnt[sel];
    other_cnt = rise ? baj_cnt[sel] : sub_cnt[sel];
    check({name, "_strobe_count"}, same_cnt, 1);
    check({name, "_other_strobe"}, other_cnt, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    raw     = 1'b0;
    raw2    = 1'b1;
    clear_counts();

    // Bounce: 13 pulses of 3 cycles alternating, then a long 0.
    for (int k = 0; k < 13; k++)
      segs.push_back('{(k % 2 == 0) ? 1'b1 : 1'b0, 3, 1'b0, 0, 0});
    segs.push_back('{1'b0, 30, 1'b0, 0, 0});
    // Near miss: 19 high samples are rejected.
    segs.push_back('{1'b1, 19, 1'b0, 0, 0});
    segs.push_back('{1'b0, 30, 1'b0, 0, 0});
    // Shortest accepted excursion: 21 high samples (the entry sample into
    // VALIDA_1 plus 20 counted ones). Rise lands on edge 23.
    segs.push_back('{1'b1, 21, 1'b0, 0, 0});
    segs.push_back('{1'b0,  1, 1'b0, 0, 0});
    segs.push_back('{1'b0,  1, 1'b1, 1, 0});
    // Release sampled first on edge 22; fall lands 23 edges later (edge 44).
    segs.push_back('{1'b0, 19, 1'b1, 0, 0});
    segs.push_back('{1'b0,  1, 1'b1, 0, 0});
    segs.push_back('{1'b0,  1, 1'b0, 0, 1});
    segs.push_back('{1'b0,  5, 1'b0, 0, 0});

    // Reset state, held for 3 cycles.
    repeat (3) step();
    check("reset_limpio", limpio, 1'b0);
    check("reset_subida", subida, 1'b0);
    check("reset_bajada", bajada, 1'b0);
    check("reset_limpio_inv", limpio2, 1'b0);
    reset_n = 1'b1;
    repeat (5) step();
    check("idle_limpio", limpio, 1'b0);

    // Clean press and clean release.
    raw = 1'b1;
    latency_check("press", 0, 1'b1);
    repeat (4) step();
    raw = 1'b0;
    latency_check("release", 0, 1'b0);
    repeat (3) step();

    // Table-driven segments.
    foreach (segs[i]) begin
      clear_counts();
      raw = segs[i].raw;
      repeat (segs[i].n) step();
      check($sformatf("seg%0d_limpio", i), limpio, segs[i].exp_limpio);
      check($sformatf("seg%0d_subida_cnt", i), sub_cnt[0], segs[i].exp_sub);
      check($sformatf("seg%0d_bajada_cnt", i), baj_cnt[0], segs[i].exp_baj);
    end

    // Reset during VALIDA_1 with cnt = 10 (edge 13 after the press).
    raw = 1'b1;
    repeat (13) step();
    reset_n = 1'b0;
    #1;
    check("midreset_limpio", limpio, 1'b0);
    check("midreset_subida", subida, 1'b0);
    check("midreset_bajada", bajada, 1'b0);
    repeat (2) step();
    reset_n = 1'b1;
    latency_check("after_reset", 0, 1'b1);

    // Reset while pressed clears the level without waiting for an edge.
    repeat (2) step();
    reset_n = 1'b0;
    #1;
    check("reset_while_high", limpio, 1'b0);
    step();
    raw = 1'b0;
    reset_n = 1'b1;
    clear_counts();
    repeat (30) step();
    check("post_reset_low", limpio, 1'b0);
    check("post_reset_no_bajada", baj_cnt[0], 0);

    // Inverted polarity: idle high has kept it released all along.
    check("inv_idle_limpio", limpio2, 1'b0);
    raw2 = 1'b0;
    latency_check("inv_press", 1, 1'b1);
    raw2 = 1'b1;
    latency_check("inv_release", 1, 1'b0);

    check("strobes_exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
